// File: rtl/s_axis_kernel_assembler.sv
// rtl/s_axis_kernel_assembler.sv - groups a backpressured pixel stream into padded fixed-length kernels
//
// Collects pixels into a fill buffer. A kernel closes when it holds KERNEL_LEN pixels
// or when tlast arrives. A closed kernel moves into a held output register, and the
// next kernel keeps filling behind it. If the output register is still occupied when
// a kernel closes, the closed kernel waits in the fill buffer (PEND) and input stalls.
//
// Ports:
//   i_clk, i_aresetn       clock (rising edge) and asynchronous active-low reset
//   i_axis_tdata/tvalid/tlast, o_axis_tready
//                          pixel input stream
//   o_kernel               assembled kernel, element 0 = oldest pixel, short kernels padded
//   o_kernel_valid/i_kernel_ready
//                          output handshake
//   o_kernel_count         real pixels in o_kernel (1..KERNEL_LEN)
//   o_kernel_last          kernel was closed by tlast
//   o_kernel_is_odd        toggles on every kernel loaded into o_kernel
module s_axis_kernel_assembler #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    KERNEL_LEN = 64,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0,
    localparam int                   CNT_W      = $clog2(KERNEL_LEN + 1)
) (
    input  logic                                  i_clk,
    input  logic                                  i_aresetn,
    input  logic [DATA_WIDTH-1:0]                 i_axis_tdata,
    input  logic                                  i_axis_tvalid,
    input  logic                                  i_axis_tlast,
    output logic                                  o_axis_tready,
    output logic [0:KERNEL_LEN-1][DATA_WIDTH-1:0] o_kernel,
    output logic                                  o_kernel_valid,
    input  logic                                  i_kernel_ready,
    output logic [CNT_W-1:0]                      o_kernel_count,
    output logic                                  o_kernel_last,
    output logic                                  o_kernel_is_odd
);

    localparam int IDX_W = $clog2(KERNEL_LEN);

    typedef enum logic {
        FILL = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t                                state;
    state_t                                state_nxt;
    logic                                  rst_done;
    logic [CNT_W-1:0]                      wr_idx;
    logic [DATA_WIDTH-1:0]                 fill [KERNEL_LEN];
    logic [CNT_W-1:0]                      pend_count;
    logic                                  pend_last;

    logic                                  accept;
    logic                                  complete;
    logic                                  slot_free;
    logic                                  load_beat;
    logic                                  load_pend;
    logic                                  go_pend;
    logic [CNT_W-1:0]                      beat_count;
    logic [0:KERNEL_LEN-1][DATA_WIDTH-1:0] beat_kernel;
    logic [0:KERNEL_LEN-1][DATA_WIDTH-1:0] pend_kernel;

    assign o_axis_tready = rst_done & (state == FILL);
    assign accept        = i_axis_tvalid & o_axis_tready;
    assign complete      = accept & ((wr_idx == CNT_W'(KERNEL_LEN - 1)) | i_axis_tlast);
    assign slot_free     = ~o_kernel_valid | i_kernel_ready;
    assign beat_count    = wr_idx + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        load_beat = 1'b0;
        load_pend = 1'b0;
        go_pend   = 1'b0;
        case (state)
            FILL: begin
                if (complete) begin
                    if (slot_free) begin
                        load_beat = 1'b1;
                    end else begin
                        go_pend   = 1'b1;
                        state_nxt = PEND;
                    end
                end
            end
            PEND: begin
                if (o_kernel_valid & i_kernel_ready) begin
                    load_pend = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Kernel images for both load paths. The closing pixel of a direct load has not
    // reached the fill buffer yet, so it is taken straight from the input bus.
    always_comb begin
        beat_kernel = '0;
        pend_kernel = '0;
        for (int i = 0; i < KERNEL_LEN; i++) begin
            if (CNT_W'(i) < wr_idx) begin
                beat_kernel[i] = fill[i];
            end else if (CNT_W'(i) == wr_idx) begin
                beat_kernel[i] = i_axis_tdata;
            end else begin
                beat_kernel[i] = PAD_VALUE;
            end
            pend_kernel[i] = (CNT_W'(i) < pend_count) ? fill[i] : PAD_VALUE;
        end
    end

    // Fill storage carries no reset: wr_idx and pend_count decide which entries are
    // real, so stale contents are always masked by padding.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            fill[wr_idx[IDX_W-1:0]] <= i_axis_tdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            rst_done        <= 1'b0;
            state           <= FILL;
            wr_idx          <= '0;
            pend_count      <= '0;
            pend_last       <= 1'b0;
            o_kernel        <= '0;
            o_kernel_valid  <= 1'b0;
            o_kernel_count  <= '0;
            o_kernel_last   <= 1'b0;
            o_kernel_is_odd <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            state    <= state_nxt;

            if (accept) begin
                wr_idx <= complete ? '0 : beat_count;
            end

            if (go_pend) begin
                pend_count <= beat_count;
                pend_last  <= i_axis_tlast;
            end

            if (load_beat) begin
                o_kernel        <= beat_kernel;
                o_kernel_count  <= beat_count;
                o_kernel_last   <= i_axis_tlast;
                o_kernel_valid  <= 1'b1;
                o_kernel_is_odd <= ~o_kernel_is_odd;
            end else if (load_pend) begin
                o_kernel        <= pend_kernel;
                o_kernel_count  <= pend_count;
                o_kernel_last   <= pend_last;
                o_kernel_valid  <= 1'b1;
                o_kernel_is_odd <= ~o_kernel_is_odd;
            end else if (o_kernel_valid & i_kernel_ready) begin
                o_kernel_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_s_axis_kernel_assembler.sv
// tb/tb_s_axis_kernel_assembler.sv - self-checking bench for s_axis_kernel_assembler
module tb_s_axis_kernel_assembler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: 64 x 8-bit, pad 0xFF
    logic            rst_a, a_tvalid, a_tlast, a_tready, a_kvalid, a_kready, a_last, a_odd;
    logic [7:0]      a_tdata;
    logic [0:63][7:0] a_kernel;
    logic [6:0]      a_count;

    // Instance B: 3 x 12-bit, pad 0xABC
    logic             rst_b, b_tvalid, b_tlast, b_tready, b_kvalid, b_kready, b_last, b_odd;
    logic [11:0]      b_tdata;
    logic [0:2][11:0] b_kernel;
    logic [1:0]       b_count;

    s_axis_kernel_assembler #(.DATA_WIDTH(8), .KERNEL_LEN(64), .PAD_VALUE(8'hFF)) dut_a (
        .i_clk(clk), .i_aresetn(rst_a), .i_axis_tdata(a_tdata), .i_axis_tvalid(a_tvalid),
        .i_axis_tlast(a_tlast), .o_axis_tready(a_tready), .o_kernel(a_kernel),
        .o_kernel_valid(a_kvalid), .i_kernel_ready(a_kready), .o_kernel_count(a_count),
        .o_kernel_last(a_last), .o_kernel_is_odd(a_odd)
    );

    s_axis_kernel_assembler #(.DATA_WIDTH(12), .KERNEL_LEN(3), .PAD_VALUE(12'hABC)) dut_b (
        .i_clk(clk), .i_aresetn(rst_b), .i_axis_tdata(b_tdata), .i_axis_tvalid(b_tvalid),
        .i_axis_tlast(b_tlast), .o_axis_tready(b_tready), .o_kernel(b_kernel),
        .o_kernel_valid(b_kvalid), .i_kernel_ready(b_kready), .o_kernel_count(b_count),
        .o_kernel_last(b_last), .o_kernel_is_odd(b_odd)
    );

    // Scoreboards: a reference assembler built from observed accepted beats pushes
    // expected kernels; every consumer handshake pops and compares one.
    typedef struct {
        logic [0:63][7:0] data;
        logic [6:0]       count;
        logic             last;
        logic             odd;
    } a_exp_t;

    typedef struct {
        logic [0:2][11:0] data;
        logic [1:0]       count;
        logic             last;
        logic             odd;
    } b_exp_t;

    a_exp_t      a_q[$];
    logic [7:0]  a_part[$];
    logic        a_odd_m = 1'b0;
    int          a_acc = 0, a_hs = 0, a_vcyc = 0, a_stall = 0, a_hs_cyc = 0, a_prev_hs_cyc = 0;

    b_exp_t      b_q[$];
    logic [11:0] b_part[$];
    logic        b_odd_m = 1'b0;
    int          b_acc = 0;

    always @(negedge clk) begin : a_scoreboard
        a_exp_t e;
        if (!rst_a) begin
            a_part.delete();
            a_q.delete();
            a_odd_m = 1'b0;
        end else begin
            if (a_kvalid) a_vcyc++;
            if (a_kvalid && a_kready) begin
                a_hs++;
                a_prev_hs_cyc = a_hs_cyc;
                a_hs_cyc      = cyc;
                checks++;
                if (a_q.size() == 0) begin
                    errors++;
                    $display("FAIL a_kernel_unexpected: got k0=%0d count=%0d, required no kernel", a_kernel[0], a_count);
                end else begin
                    e = a_q.pop_front();
                    if (a_kernel !== e.data || a_count !== e.count || a_last !== e.last || a_odd !== e.odd) begin
                        errors++;
                        $display("FAIL a_kernel: got k0=%h k63=%h count=%0d last=%b odd=%b, required k0=%h k63=%h count=%0d last=%b odd=%b",
                                 a_kernel[0], a_kernel[63], a_count, a_last, a_odd,
                                 e.data[0], e.data[63], e.count, e.last, e.odd);
                    end
                end
            end
            if (a_tvalid && a_tready) begin
                a_acc++;
                a_part.push_back(a_tdata);
                if (a_part.size() == 64 || a_tlast) begin
                    a_odd_m = ~a_odd_m;
                    for (int k = 0; k < 64; k++) begin
                        if (k < a_part.size()) e.data[k] = a_part[k];
                        else                   e.data[k] = 8'hFF;
                    end
                    e.count = 7'(a_part.size());
                    e.last  = a_tlast;
                    e.odd   = a_odd_m;
                    a_q.push_back(e);
                    a_part.delete();
                end
            end
        end
    end

    always @(negedge clk) begin : b_scoreboard
        b_exp_t e;
        if (!rst_b) begin
            b_part.delete();
            b_q.delete();
            b_odd_m = 1'b0;
        end else begin
            if (b_kvalid && b_kready) begin
                checks++;
                if (b_q.size() == 0) begin
                    errors++;
                    $display("FAIL b_kernel_unexpected: got k0=%h count=%0d, required no kernel", b_kernel[0], b_count);
                end else begin
                    e = b_q.pop_front();
                    if (b_kernel !== e.data || b_count !== e.count || b_last !== e.last || b_odd !== e.odd) begin
                        errors++;
                        $display("FAIL b_kernel: got %h/%h/%h count=%0d last=%b odd=%b, required %h/%h/%h count=%0d last=%b odd=%b",
                                 b_kernel[0], b_kernel[1], b_kernel[2], b_count, b_last, b_odd,
                                 e.data[0], e.data[1], e.data[2], e.count, e.last, e.odd);
                    end
                end
            end
            if (b_tvalid && b_tready) begin
                b_acc++;
                b_part.push_back(b_tdata);
                if (b_part.size() == 3 || b_tlast) begin
                    b_odd_m = ~b_odd_m;
                    for (int k = 0; k < 3; k++) begin
                        if (k < b_part.size()) e.data[k] = b_part[k];
                        else                   e.data[k] = 12'hABC;
                    end
                    e.count = 2'(b_part.size());
                    e.last  = b_tlast;
                    e.odd   = b_odd_m;
                    b_q.push_back(e);
                    b_part.delete();
                end
            end
        end
    end

    // Drivers: present one beat and return just after the edge that accepts it,
    // leaving tvalid high so consecutive calls produce gap-free bursts.
    task automatic a_send(input logic [7:0] d, input logic l);
        a_tdata = d; a_tvalid = 1'b1; a_tlast = l;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (a_tready) begin
                @(posedge clk); #1;
                return;
            end
            a_stall++;
        end
        checks++; errors++;
        $display("FAIL a_send_timeout: pixel %0d not accepted, required acceptance within 2000 cycles", d);
    endtask

    task automatic a_idle();
        a_tvalid = 1'b0; a_tlast = 1'b0;
    endtask

    task automatic b_send(input logic [11:0] d, input logic l);
        b_tdata = d; b_tvalid = 1'b1; b_tlast = l;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (b_tready) begin
                @(posedge clk); #1;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL b_send_timeout: pixel %h not accepted, required acceptance within 2000 cycles", d);
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_kvalid, a_last, a_odd, a_tready} !== 4'b0 || a_count !== 7'd0 || a_kernel !== '0) begin
            errors++;
            $display("FAIL reset_a: got valid=%b last=%b odd=%b tready=%b count=%0d k0=%h, required all 0",
                     a_kvalid, a_last, a_odd, a_tready, a_count, a_kernel[0]);
        end
        checks++;
        if ({b_kvalid, b_last, b_odd, b_tready} !== 4'b0 || b_count !== 2'd0 || b_kernel !== '0) begin
            errors++;
            $display("FAIL reset_b: got valid=%b last=%b odd=%b tready=%b count=%0d, required all 0",
                     b_kvalid, b_last, b_odd, b_tready, b_count);
        end
        @(posedge clk); #1;
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        checks++;
        if (a_tready !== 1'b0 || b_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_tready_low: got a=%b b=%b, required 0 in the cycle after release", a_tready, b_tready);
        end
        @(negedge clk);
        checks++;
        if (a_tready !== 1'b1 || b_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready_rise: got a=%b b=%b, required 1", a_tready, b_tready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_kernels();
        int hs0, v0, st0;
        hs0 = a_hs; v0 = a_vcyc; st0 = a_stall;
        a_kready = 1'b1;
        for (int i = 0; i < 128; i++) a_send(8'(i), 1'b0);
        a_idle();
        repeat (4) @(posedge clk); #1;
        checks++;
        if (a_hs - hs0 !== 2 || a_vcyc - v0 !== 2) begin
            errors++;
            $display("FAIL full_valid_pulses: got handshakes=%0d valid_cycles=%0d, required 2 and 2", a_hs - hs0, a_vcyc - v0);
        end
        checks++;
        if (a_hs_cyc - a_prev_hs_cyc !== 64) begin
            errors++;
            $display("FAIL full_spacing: got %0d cycles between kernels, required 64", a_hs_cyc - a_prev_hs_cyc);
        end
        checks++;
        if (a_stall - st0 !== 0 || a_q.size() !== 0) begin
            errors++;
            $display("FAIL full_no_stall: got stalls=%0d outstanding=%0d, required 0 and 0", a_stall - st0, a_q.size());
        end
    endtask

    task automatic test_tlast_pad();
        a_kready = 1'b0;
        for (int i = 0; i < 10; i++) a_send(8'(i), i == 9);
        a_idle();
        @(negedge clk);
        checks++;
        if (a_kvalid !== 1'b1 || a_count !== 7'd10 || a_last !== 1'b1) begin
            errors++;
            $display("FAIL pad_meta: got valid=%b count=%0d last=%b, required 1 10 1", a_kvalid, a_count, a_last);
        end
        checks++;
        if (a_kernel[9] !== 8'd9 || a_kernel[10] !== 8'hFF || a_kernel[63] !== 8'hFF) begin
            errors++;
            $display("FAIL pad_data: got k9=%h k10=%h k63=%h, required 09 ff ff", a_kernel[9], a_kernel[10], a_kernel[63]);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (a_kvalid !== 1'b1 || a_count !== 7'd10 || a_kernel[0] !== 8'd0 || a_kernel[10] !== 8'hFF) begin
            errors++;
            $display("FAIL pad_hold: got valid=%b count=%0d k0=%h k10=%h, required 1 10 00 ff", a_kvalid, a_count, a_kernel[0], a_kernel[10]);
        end
        @(posedge clk); #1;
        a_kready = 1'b1;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int acc0;
        acc0 = a_acc;
        a_kready = 1'b0;
        fork
            begin
                for (int i = 0; i < 130; i++) a_send(8'(i), i == 129);
                a_idle();
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int n = 0; n < 400 && !seen; n++) begin
                    @(negedge clk);
                    if (!a_tready) seen = 1'b1;
                end
                checks++;
                if (!seen || a_acc - acc0 !== 128) begin
                    errors++;
                    $display("FAIL pend_entry: got tready_low=%b accepted=%0d, required 1 and 128", seen, a_acc - acc0);
                end
                @(posedge clk); #1; a_kready = 1'b1;
                @(posedge clk); #1; a_kready = 1'b0;
                @(negedge clk);
                checks++;
                if (a_tready !== 1'b1 || a_kvalid !== 1'b1 || a_kernel[0] !== 8'd64 || a_count !== 7'd64) begin
                    errors++;
                    $display("FAIL pend_exit: got tready=%b valid=%b k0=%0d count=%0d, required 1 1 64 64",
                             a_tready, a_kvalid, a_kernel[0], a_count);
                end
                repeat (5) @(posedge clk); #1;
                a_kready = 1'b1;
            end
        join
        repeat (4) @(posedge clk); #1;
        checks++;
        if (a_acc - acc0 !== 130 || a_q.size() !== 0) begin
            errors++;
            $display("FAIL pend_no_loss: got accepted=%0d outstanding=%0d, required 130 and 0", a_acc - acc0, a_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int hs0, v0, st0;
        hs0 = a_hs; v0 = a_vcyc; st0 = a_stall;
        a_kready = 1'b1;
        for (int i = 0; i < 5; i++) a_send(8'(200 + i), 1'b1);
        a_send(8'd210, 1'b0);
        a_send(8'd211, 1'b0);
        a_send(8'd212, 1'b1);
        a_idle();
        repeat (4) @(posedge clk); #1;
        checks++;
        if (a_stall - st0 !== 0 || a_hs - hs0 !== 6 || a_vcyc - v0 !== 6) begin
            errors++;
            $display("FAIL back_to_back: got stalls=%0d handshakes=%0d valid_cycles=%0d, required 0 6 6",
                     a_stall - st0, a_hs - hs0, a_vcyc - v0);
        end
    endtask

    task automatic test_reset_mid_kernel();
        int hs0;
        a_kready = 1'b1;
        for (int i = 0; i < 30; i++) a_send(8'(i), 1'b0);
        a_idle();
        rst_a = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_kvalid, a_last, a_odd, a_tready} !== 4'b0 || a_count !== 7'd0 || a_kernel !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got valid=%b last=%b odd=%b tready=%b count=%0d k0=%h, required all 0",
                     a_kvalid, a_last, a_odd, a_tready, a_count, a_kernel[0]);
        end
        @(posedge clk); #1;
        rst_a = 1'b1;
        @(negedge clk);
        checks++;
        if (a_tready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_tready_low: got %b, required 0", a_tready);
        end
        @(posedge clk); #1;
        hs0 = a_hs;
        for (int i = 0; i < 64; i++) a_send(8'(100 + i), i == 63);
        a_idle();
        repeat (3) @(posedge clk); #1;
        checks++;
        if (a_hs - hs0 !== 1 || a_q.size() !== 0) begin
            errors++;
            $display("FAIL midreset_fresh: got handshakes=%0d outstanding=%0d, required 1 and 0", a_hs - hs0, a_q.size());
        end
    endtask

    task automatic test_random_small();
        int acc0;
        bit done;
        acc0 = b_acc;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    int gap;
                    gap = $urandom_range(0, 2);
                    if (gap > 0) begin
                        b_tvalid = 1'b0;
                        b_tdata  = 12'($urandom);
                        b_tlast  = 1'($urandom);
                        repeat (gap) @(posedge clk);
                        #1;
                    end
                    b_send(12'($urandom), (i == 999) || ($urandom_range(0, 4) == 0));
                end
                b_tvalid = 1'b0; b_tlast = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    b_kready = 1'($urandom_range(0, 1));
                end
                b_kready = 1'b1;
            end
        join
        repeat (10) @(posedge clk); #1;
        checks++;
        if (b_acc - acc0 !== 1000 || b_q.size() !== 0 || b_part.size() !== 0) begin
            errors++;
            $display("FAIL random_drain: got accepted=%0d outstanding=%0d partial=%0d, required 1000 0 0",
                     b_acc - acc0, b_q.size(), b_part.size());
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        a_tdata = '0; a_tvalid = 1'b0; a_tlast = 1'b0; a_kready = 1'b0;
        b_tdata = '0; b_tvalid = 1'b0; b_tlast = 1'b0; b_kready = 1'b0;
        test_reset();
        test_full_kernels();
        test_tlast_pad();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_kernel();
        test_random_small();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/s_axis_kernel_assembler.md
# s_axis_kernel_assembler

Parametrised successor to the pixel-to-kernel remapper. It accepts an AXI4-Stream pixel stream with backpressure and `tlast` and assembles pixels into kernels of `KERNEL_LEN` elements. A kernel that `tlast` ends early is padded out. Each completed kernel goes into a held output register behind a valid/ready handshake, while the next kernel fills in parallel. It sits between the pixel source (DMA or sensor front end) and the kernel-processing datapath.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: pixel width in bits.
- `KERNEL_LEN`, default 64: pixels per kernel, minimum 2.
- `PAD_VALUE`, default 0: value written to unfilled elements of a short kernel.
- `CNT_W`, derived, not overridden: `$clog2(KERNEL_LEN+1)`.

Ports:
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_aresetn`  in  1  asynchronous, active-low reset.
- `i_axis_tdata`  in  DATA_WIDTH  pixel.
- `i_axis_tvalid`  in  1  pixel valid.
- `i_axis_tlast`  in  1  last pixel of a line/frame; closes the current kernel.
- `o_axis_tready`  out  1  assembler can accept a pixel.
- `o_kernel`  out  [0:KERNEL_LEN-1][DATA_WIDTH-1:0]  kernel; element 0 is the oldest pixel.
- `o_kernel_valid`  out  1  `o_kernel` holds an unconsumed kernel.
- `i_kernel_ready`  in  1  consumer takes the kernel when high with valid.
- `o_kernel_count`  out  CNT_W  number of real pixels in `o_kernel`, 1..KERNEL_LEN.
- `o_kernel_last`  out  1  the kernel was closed by `tlast`.
- `o_kernel_is_odd`  out  1  toggles on every kernel loaded into the output register.

## Operation
- Beat accepted = `i_axis_tvalid & o_axis_tready`.
- Fill buffer:
  - An accepted beat writes `fill[wr_idx]`.
  - `wr_idx` (CNT_W bits) increments by 1.
- Completing beat: an accepted beat with `wr_idx == KERNEL_LEN-1` or `i_axis_tlast == 1`.
  - Kernel size is `wr_idx+1`.
  - Elements with index greater than `wr_idx` read as `PAD_VALUE`.
  - `wr_idx` returns to 0.
  - `tlast` on the final element gives a full-length kernel with `o_kernel_last = 1`.
- Output slot free = `~o_kernel_valid | i_kernel_ready`.
- FSM for the fill side, two states:
  - **FILL**:
    - Completing beat with slot free: load the output register (data with padding applied, count, last). Set `o_kernel_valid`. Toggle `o_kernel_is_odd`. Stay in FILL.
    - Completing beat with slot not free: latch the kernel into the fill buffer with its count/last and go to **PEND**.
  - **PEND**:
    - `o_axis_tready = 0`.
    - When `o_kernel_valid & i_kernel_ready`: move the pending kernel to the output, keep `o_kernel_valid = 1`, toggle odd, go to FILL.
- Output side:
  - `o_kernel_valid` clears on `valid & ready` unless a new kernel loads in the same cycle.
  - While `o_kernel_valid = 1` and `i_kernel_ready = 0`, `o_kernel`, `o_kernel_count` and `o_kernel_last` are stable.
- `o_axis_tready = rst_done & (state == FILL)`.
  - `rst_done` is a flop that resets to 0 and sets on the first clock after reset release.

## Timing
- Reset values:
  - `o_kernel` all `'0`.
  - `o_kernel_valid`, `o_kernel_last`, `o_kernel_is_odd` = 0.
  - `o_kernel_count` = 0.
  - `o_axis_tready` = 0.
  - Internal state: FILL, `wr_idx` = 0.
- `o_axis_tready` rises 1 cycle after `i_aresetn` deasserts.
- Latency: `o_kernel_valid` is high in the cycle after the edge that accepts the completing beat.
- Throughput: with `i_kernel_ready` held at 1, the assembler accepts a pixel every cycle with no bubbles. A new kernel loads in the same cycle the previous one is consumed.
- PEND exit: a consumer handshake at edge N returns `o_axis_tready` high in cycle N+1. That handshake also shows the new kernel in cycle N+1.
- Simultaneous events:
  - Completing beat and consumer handshake in the same cycle: the new kernel loads with no stall.
  - `tlast` on a kernel's first pixel gives `o_kernel_count = 1` and elements 1.. equal to `PAD_VALUE`.
- `i_axis_tdata` and `i_axis_tlast` are ignored when the beat is not accepted.
- Reset mid-kernel discards partial and pending kernels. No output pulses on reset.

## Test plan
- `KERNEL_LEN=64`, 128 pixels 0..127, consumer always ready:
  - two kernels, valid one cycle each, 64 cycles apart;
  - `o_kernel[0]` = 0 then 64;
  - count = 64, odd sequence 1 then 0;
  - `tready` never drops.
- `tlast` on pixel 9 of 0..9, `PAD_VALUE=8'hFF`:
  - `o_kernel[0..9]` = 0..9, `[10..63]` = FF;
  - count = 10, last = 1.
- Consumer ready held 0 after first kernel, 130 pixels offered:
  - second kernel pends and `tready` falls after pixel 127;
  - raising ready once shows the second kernel next cycle and `tready` high that cycle;
  - no pixel lost or duplicated.
- Completing beat and consumer handshake in the same cycle: back-to-back valid, `tready` stays 1, count correct.
- Assert `i_aresetn` low at pixel 30 then release:
  - all outputs 0;
  - `tready` 0 for one cycle after release;
  - next kernel starts at element 0 with fresh data.
- `KERNEL_LEN=3`, `DATA_WIDTH=12`, random tvalid/ready: scoreboard matches for 1000 pixels with random `tlast`.
